// File: rtl/cfu_gemm_ctrl.sv
// cfu_gemm_ctrl: custom-instruction command front-end for the A/B/C global
// buffers and the GEMM core. Decodes opcodes, issues single-word A/B writes,
// lane-selected C reads, and launches compute, answering once the core is done.
// Optional feature macro: CFU_AUTOINC_EN (auto-increment buffer pointers and
// bounded WAIT with timeout response).
module cfu_gemm_ctrl #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned AB_BITS   = 32,
  parameter int unsigned C_BITS    = 128,
  parameter int unsigned DIM_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [9:0]           cmd_payload_function_id,
  input  logic [31:0]          cmd_payload_inputs_0,
  input  logic [31:0]          cmd_payload_inputs_1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_payload_outputs_0,
  output logic                 a_wr_en,
  output logic                 b_wr_en,
  output logic [ADDR_BITS-1:0] a_index,
  output logic [ADDR_BITS-1:0] b_index,
  output logic [ADDR_BITS-1:0] c_index,
  output logic [AB_BITS-1:0]   a_data_in,
  output logic [AB_BITS-1:0]   b_data_in,
  input  logic [C_BITS-1:0]    c_data_out,
  input  logic [ADDR_BITS-1:0] core_a_index,
  input  logic [ADDR_BITS-1:0] core_b_index,
  input  logic [ADDR_BITS-1:0] core_c_index,
  output logic                 core_in_valid,
  output logic [DIM_BITS-1:0]  core_m,
  output logic [DIM_BITS-1:0]  core_k,
  output logic [DIM_BITS-1:0]  core_n,
  input  logic                 core_busy
);

  localparam int unsigned LANES     = C_BITS / 32;
  localparam int unsigned WAIT_BITS = 16;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_WRITE   = 3'd1;
  localparam logic [2:0] OP_COMPUTE = 3'd2;
  localparam logic [2:0] OP_READ_C  = 3'd3;
  localparam logic [2:0] OP_STATUS  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WR, ST_RD_ADDR, ST_RD_DATA, ST_EXEC, ST_WAIT, ST_RSP
  } state_e;

  state_e               state_q, state_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_data_q, rsp_data_d;
  logic                 a_wr_en_q, a_wr_en_d;
  logic                 b_wr_en_q, b_wr_en_d;
  logic [ADDR_BITS-1:0] a_idx_q, a_idx_d;
  logic [ADDR_BITS-1:0] b_idx_q, b_idx_d;
  logic [ADDR_BITS-1:0] c_idx_q, c_idx_d;
  logic [AB_BITS-1:0]   wdata_q, wdata_d;
  logic                 in_valid_q, in_valid_d;
  logic [DIM_BITS-1:0]  m_q, m_d, k_q, k_d, n_q, n_d;
  logic [2:0]           op_q, op_d;
  logic [1:0]           lane_q, lane_d;
  logic                 seen_busy_q, seen_busy_d;
  logic                 err_q, err_d;
`ifdef CFU_AUTOINC_EN
  logic [ADDR_BITS-1:0] a_ptr_q, a_ptr_d;
  logic [ADDR_BITS-1:0] b_ptr_q, b_ptr_d;
  logic [ADDR_BITS-1:0] c_ptr_q, c_ptr_d;
  logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
`endif

  logic [2:0]           op_c;
  logic                 sel_b_c;
  logic                 auto_c;
  logic [ADDR_BITS-1:0] idx_in_c;
  logic [DIM_BITS-1:0]  dim_m_c, dim_k_c, dim_n_c;
  logic [31:0]          lane_word_c;
  logic                 core_owns_c;
  logic                 unused_in;

  assign op_c     = cmd_payload_function_id[2:0];
  assign sel_b_c  = cmd_payload_function_id[8];
`ifdef CFU_AUTOINC_EN
  assign auto_c   = cmd_payload_function_id[7];
`else
  assign auto_c   = 1'b0;
`endif
  assign idx_in_c = cmd_payload_inputs_0[ADDR_BITS-1:0];
  assign dim_m_c  = cmd_payload_inputs_0[DIM_BITS-1:0];
  assign dim_k_c  = cmd_payload_inputs_1[16 +: DIM_BITS];
  assign dim_n_c  = cmd_payload_inputs_1[0 +: DIM_BITS];

  // Operand bits outside the decoded fields are intentionally ignored.
  assign unused_in = ^{cmd_payload_function_id, cmd_payload_inputs_0,
                       cmd_payload_inputs_1, err_q, WAIT_BITS[0]};

  // Select the requested 32-bit lane of the C word; lanes beyond the word read 0.
  always_comb begin
    lane_word_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (32'(lane_q) == i) lane_word_c = c_data_out[32*i +: 32];
    end
  end

  // Buffer indices belong to the core only while it is computing.
  assign core_owns_c = (state_q == ST_EXEC) || (state_q == ST_WAIT);
  assign a_index     = core_owns_c ? core_a_index : a_idx_q;
  assign b_index     = core_owns_c ? core_b_index : b_idx_q;
  assign c_index     = core_owns_c ? core_c_index : c_idx_q;

  assign cmd_ready             = cmd_ready_q;
  assign rsp_valid             = rsp_valid_q;
  assign rsp_payload_outputs_0 = rsp_data_q;
  assign a_wr_en               = a_wr_en_q;
  assign b_wr_en               = b_wr_en_q;
  assign a_data_in             = wdata_q;
  assign b_data_in             = wdata_q;
  assign core_in_valid         = in_valid_q;
  assign core_m                = m_q;
  assign core_k                = k_q;
  assign core_n                = n_q;

  // Next-state and registered-output logic of the command FSM.
  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    a_wr_en_d   = 1'b0;
    b_wr_en_d   = 1'b0;
    a_idx_d     = a_idx_q;
    b_idx_d     = b_idx_q;
    c_idx_d     = c_idx_q;
    wdata_d     = wdata_q;
    in_valid_d  = 1'b0;
    m_d         = m_q;
    k_d         = k_q;
    n_d         = n_q;
    op_d        = op_q;
    lane_d      = lane_q;
    seen_busy_d = seen_busy_q;
    err_d       = err_q;
`ifdef CFU_AUTOINC_EN
    a_ptr_d     = a_ptr_q;
    b_ptr_d     = b_ptr_q;
    c_ptr_d     = c_ptr_q;
    wait_cnt_d  = wait_cnt_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          op_d        = op_c;
          case (op_c)
            OP_NOP: begin
              rsp_data_d = 32'h0;
              err_d      = 1'b0;
`ifdef CFU_AUTOINC_EN
              a_ptr_d    = '0;
              b_ptr_d    = '0;
              c_ptr_d    = '0;
`endif
              state_d    = ST_RSP;
            end
            OP_WRITE: begin
              wdata_d = AB_BITS'(cmd_payload_inputs_1);
              if (sel_b_c) begin
                b_wr_en_d = 1'b1;
                b_idx_d   = idx_in_c;
`ifdef CFU_AUTOINC_EN
                if (auto_c) begin
                  b_idx_d = b_ptr_q;
                  b_ptr_d = b_ptr_q + ADDR_BITS'(1);
                end
`endif
              end else begin
                a_wr_en_d = 1'b1;
                a_idx_d   = idx_in_c;
`ifdef CFU_AUTOINC_EN
                if (auto_c) begin
                  a_idx_d = a_ptr_q;
                  a_ptr_d = a_ptr_q + ADDR_BITS'(1);
                end
`endif
              end
              state_d = ST_WR;
            end
            OP_COMPUTE: begin
              m_d = dim_m_c;
              k_d = dim_k_c;
              n_d = dim_n_c;
              if ((dim_m_c == '0) || (dim_k_c == '0) || (dim_n_c == '0)) begin
                rsp_data_d = 32'hFFFF_FFFE;
                err_d      = 1'b1;
                state_d    = ST_RSP;
              end else begin
                in_valid_d  = 1'b1;
                seen_busy_d = 1'b0;
`ifdef CFU_AUTOINC_EN
                wait_cnt_d  = '0;
`endif
                state_d     = ST_EXEC;
              end
            end
            OP_READ_C: begin
              c_idx_d = idx_in_c;
`ifdef CFU_AUTOINC_EN
              if (auto_c) begin
                c_idx_d = c_ptr_q;
                c_ptr_d = c_ptr_q + ADDR_BITS'(1);
              end
`endif
              lane_d  = cmd_payload_inputs_1[1:0];
              state_d = ST_RD_ADDR;
            end
            OP_STATUS: begin
              state_d = ST_RSP;
            end
            default: begin
              rsp_data_d = 32'hFFFF_FFFF;
              err_d      = 1'b1;
              state_d    = ST_RSP;
            end
          endcase
        end
      end
      ST_WR: begin
        rsp_data_d  = 32'h0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RD_ADDR: begin
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        rsp_data_d  = lane_word_c;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_EXEC: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (core_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy_q) begin
          rsp_data_d  = 32'h1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end
`ifdef CFU_AUTOINC_EN
        else if (wait_cnt_q == '1) begin
          rsp_data_d  = 32'hFFFF_FFFD;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
          state_d     = ST_RSP;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
        end
`endif
      end
      ST_RSP: begin
        if (!rsp_valid_q) begin
          // Commands answered straight from IDLE raise valid one cycle later.
          rsp_valid_d = 1'b1;
          if (op_q == OP_STATUS) rsp_data_d = {31'b0, core_busy};
        end else if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      a_wr_en_q   <= 1'b0;
      b_wr_en_q   <= 1'b0;
      a_idx_q     <= '0;
      b_idx_q     <= '0;
      c_idx_q     <= '0;
      wdata_q     <= '0;
      in_valid_q  <= 1'b0;
      m_q         <= '0;
      k_q         <= '0;
      n_q         <= '0;
      op_q        <= '0;
      lane_q      <= '0;
      seen_busy_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef CFU_AUTOINC_EN
      a_ptr_q     <= '0;
      b_ptr_q     <= '0;
      c_ptr_q     <= '0;
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      a_wr_en_q   <= a_wr_en_d;
      b_wr_en_q   <= b_wr_en_d;
      a_idx_q     <= a_idx_d;
      b_idx_q     <= b_idx_d;
      c_idx_q     <= c_idx_d;
      wdata_q     <= wdata_d;
      in_valid_q  <= in_valid_d;
      m_q         <= m_d;
      k_q         <= k_d;
      n_q         <= n_d;
      op_q        <= op_d;
      lane_q      <= lane_d;
      seen_busy_q <= seen_busy_d;
      err_q       <= err_d;
`ifdef CFU_AUTOINC_EN
      a_ptr_q     <= a_ptr_d;
      b_ptr_q     <= b_ptr_d;
      c_ptr_q     <= c_ptr_d;
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_cfu_gemm_ctrl.sv
// Testbench for cfu_gemm_ctrl: scoreboard of expected response words, a
// C-buffer model with one-cycle read latency and a core model that stays busy
// for 10 cycles after each start pulse.
module tb_cfu_gemm_ctrl;

  localparam int unsigned ADDR_BITS = 12;
  localparam int unsigned AB_BITS   = 32;
  localparam int unsigned C_BITS    = 128;
  localparam int unsigned DIM_BITS  = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [9:0]           fid;
  logic [31:0]          in0, in1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [31:0]          rsp_data;
  logic                 a_wr_en, b_wr_en;
  logic [ADDR_BITS-1:0] a_index, b_index, c_index;
  logic [AB_BITS-1:0]   a_data_in, b_data_in;
  logic [C_BITS-1:0]    c_data_out = '0;
  logic [ADDR_BITS-1:0] core_a_index, core_b_index, core_c_index;
  logic                 core_in_valid;
  logic [DIM_BITS-1:0]  core_m, core_k, core_n;
  logic                 core_busy;
  logic                 busy_force;
  int                   busy_cnt = 0;
  int                   pulses = 0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign core_a_index = 12'h0A1;
  assign core_b_index = 12'h0B2;
  assign core_c_index = 12'h0C3;

  cfu_gemm_ctrl #(
    .ADDR_BITS(ADDR_BITS), .AB_BITS(AB_BITS), .C_BITS(C_BITS), .DIM_BITS(DIM_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_payload_function_id(fid),
    .cmd_payload_inputs_0(in0), .cmd_payload_inputs_1(in1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_payload_outputs_0(rsp_data),
    .a_wr_en(a_wr_en), .b_wr_en(b_wr_en),
    .a_index(a_index), .b_index(b_index), .c_index(c_index),
    .a_data_in(a_data_in), .b_data_in(b_data_in),
    .c_data_out(c_data_out),
    .core_a_index(core_a_index), .core_b_index(core_b_index), .core_c_index(core_c_index),
    .core_in_valid(core_in_valid),
    .core_m(core_m), .core_k(core_k), .core_n(core_n),
    .core_busy(core_busy)
  );

  // Known C-buffer contents: lane 2 of word 5 is 0x1234, other lanes tagged.
  function automatic logic [31:0] c_lane(input logic [ADDR_BITS-1:0] idx, input int l);
    if (idx == 12'd5 && l == 2) return 32'h0000_1234;
    return {8'hC0 + 8'(l), 12'h000, idx};
  endfunction

  function automatic logic [C_BITS-1:0] c_line(input logic [ADDR_BITS-1:0] idx);
    logic [C_BITS-1:0] v;
    for (int l = 0; l < 4; l++) v[32*l +: 32] = c_lane(idx, l);
    return v;
  endfunction

  function automatic logic [9:0] mk_fid(input logic [6:0] funct, input logic [2:0] op);
    return {funct, op};
  endfunction

  // C buffer read: data follows the index by one cycle.
  always @(posedge clk) c_data_out <= c_line(c_index);

  // Core model: busy for 10 cycles after each start pulse; count the pulses.
  always @(posedge clk) begin
    if (core_in_valid) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    if (core_in_valid) pulses <= pulses + 1;
  end
  assign core_busy = busy_force || (busy_cnt != 0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive one command; returns at the sample point of cycle +1.
  task automatic issue(input logic [9:0] f, input logic [31:0] i0, input logic [31:0] i1);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    fid = f;
    in0 = i0;
    in1 = i1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    fid = 10'h3FF;
    in0 = 32'hFFFF_FFFF;
    in1 = 32'hFFFF_FFFF;
    @(negedge clk);
  endtask

  // Wait for the response, compare against the scoreboard, optionally stall.
  task automatic wait_rsp(input int start, input int lat, input int stall, input string tag);
    int n;
    logic [31:0] e;
    n = start;
    while (!rsp_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_nowr"}, 32'(a_wr_en | b_wr_en), 32'd0);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: response with empty scoreboard, got 0x%08h", tag, rsp_data);
      e = rsp_data;
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, rsp_data, e);
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "_hold_data"}, rsp_data, e);
      check({tag, "_hold_ready"}, 32'(cmd_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check({tag, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct { logic [31:0] idx; logic [31:0] lane; } rd_t;
  typedef struct { logic [31:0] m; logic [31:0] kn; } cmp_t;

  initial begin
    rd_t  rd_tab[4];
    cmp_t zero_tab[4];
    int   p0;

    rd_tab[0] = '{32'd5, 32'd2};
    rd_tab[1] = '{32'd7, 32'd0};
    rd_tab[2] = '{32'hABC, 32'd3};
    rd_tab[3] = '{32'h1FFF, 32'd1};
    zero_tab[0] = '{32'd4, 32'h0000_0004};
    zero_tab[1] = '{32'd0, 32'h0008_0004};
    zero_tab[2] = '{32'd4, 32'h0008_0000};
    zero_tab[3] = '{32'h100, 32'h0008_0004};

    reset = 1'b1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    busy_force = 1'b0;
    fid = '0;
    in0 = '0;
    in1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_a_wr_en", 32'(a_wr_en), 32'd0);
    check("rst_b_wr_en", 32'(b_wr_en), 32'd0);
    check("rst_in_valid", 32'(core_in_valid), 32'd0);
    check("rst_payload", rsp_data, 32'd0);
    check("rst_a_index", 32'(a_index), 32'd0);

    // WRITE A index 5.
    exp_q.push_back(32'd0);
    issue(mk_fid(7'h00, 3'd1), 32'd5, 32'hDEAD_BEEF);
    check("wr_a_en", 32'(a_wr_en), 32'd1);
    check("wr_a_idx", 32'(a_index), 32'd5);
    check("wr_a_data", a_data_in, 32'hDEAD_BEEF);
    check("wr_a_b_en", 32'(b_wr_en), 32'd0);
    wait_rsp(1, 2, 0, "wr_a");

    // WRITE B with an index wider than the buffer.
    exp_q.push_back(32'd0);
    issue(mk_fid(7'h20, 3'd1), 32'hFFFF_F123, 32'hCAFE_0001);
    check("wr_b_en", 32'(b_wr_en), 32'd1);
    check("wr_b_idx", 32'(b_index), 32'h123);
    check("wr_b_data", b_data_in, 32'hCAFE_0001);
    check("wr_b_a_en", 32'(a_wr_en), 32'd0);
    wait_rsp(1, 2, 0, "wr_b");

    // READ_C across lanes and a truncated index.
    foreach (rd_tab[i]) begin
      exp_q.push_back(c_lane(rd_tab[i].idx[ADDR_BITS-1:0], int'(rd_tab[i].lane)));
      issue(mk_fid(7'h00, 3'd3), rd_tab[i].idx, rd_tab[i].lane);
      check("rd_c_idx", 32'(c_index), 32'(rd_tab[i].idx[ADDR_BITS-1:0]));
      wait_rsp(1, 3, 0, "rd_c");
    end

    // STATUS idle, then with busy high in IDLE plus response backpressure.
    exp_q.push_back(32'd0);
    issue(mk_fid(7'h00, 3'd4), 32'd0, 32'd0);
    wait_rsp(1, 2, 0, "status0");
    busy_force = 1'b1;
    exp_q.push_back(32'd1);
    issue(mk_fid(7'h00, 3'd4), 32'd0, 32'd0);
    wait_rsp(1, 2, 5, "status1");
    busy_force = 1'b0;

    // COMPUTE M=4 K=8 N=4 with the core busy for 10 cycles.
    p0 = pulses;
    exp_q.push_back(32'd1);
    issue(mk_fid(7'h00, 3'd2), 32'd4, 32'h0008_0004);
    check("cmp_in_valid", 32'(core_in_valid), 32'd1);
    check("cmp_m", 32'(core_m), 32'd4);
    check("cmp_k", 32'(core_k), 32'd8);
    check("cmp_n", 32'(core_n), 32'd4);
    check("cmp_a_route", 32'(a_index), 32'h0A1);
    check("cmp_b_route", 32'(b_index), 32'h0B2);
    check("cmp_c_route", 32'(c_index), 32'h0C3);
    @(negedge clk);
    check("cmp_pulse_end", 32'(core_in_valid), 32'd0);
    check("cmp_wait_route", 32'(a_index), 32'h0A1);
    check("cmp_k_held", 32'(core_k), 32'd8);
    wait_rsp(2, 13, 0, "compute");
    check("cmp_pulses", 32'(pulses - p0), 32'd1);
    check("cmp_a_back", 32'(a_index), 32'd5);

    // COMPUTE with a zero dimension never launches.
    p0 = pulses;
    foreach (zero_tab[i]) begin
      exp_q.push_back(32'hFFFF_FFFE);
      issue(mk_fid(7'h00, 3'd2), zero_tab[i].m, zero_tab[i].kn);
      check("zero_in_valid", 32'(core_in_valid), 32'd0);
      wait_rsp(1, 2, 0, "cmp_zero");
    end
    check("zero_pulses", 32'(pulses - p0), 32'd0);

    // Undefined opcodes, then NOP/CLR.
    for (int op = 5; op < 8; op++) begin
      exp_q.push_back(32'hFFFF_FFFF);
      issue(mk_fid(7'h00, 3'(op)), 32'd1, 32'd1);
      wait_rsp(1, 2, 0, "bad_op");
    end
    exp_q.push_back(32'd0);
    issue(mk_fid(7'h00, 3'd0), 32'd0, 32'd0);
    wait_rsp(1, 2, 0, "nop");

    // Reset while waiting on the core.
    issue(mk_fid(7'h00, 3'd2), 32'd2, 32'h0002_0002);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_wait_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wait_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_wait_in_valid", 32'(core_in_valid), 32'd0);
    check("rst_wait_a_index", 32'(a_index), 32'd0);
    check("rst_wait_m", 32'(core_m), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    exp_q.push_back(32'd0);
    issue(mk_fid(7'h00, 3'd4), 32'd0, 32'd0);
    wait_rsp(1, 2, 0, "post_rst");

`ifdef CFU_AUTOINC_EN
    // Auto-increment B pointer after CLR, then wrap of the A pointer.
    exp_q.push_back(32'd0);
    issue(mk_fid(7'h00, 3'd0), 32'd0, 32'd0);
    wait_rsp(1, 2, 0, "clr");
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'd0);
      issue(mk_fid(7'h30, 3'd1), 32'h0000_0999, 32'(i));
      check("auto_b_en", 32'(b_wr_en), 32'd1);
      check("auto_b_idx", 32'(b_index), 32'(i));
      wait_rsp(1, 2, 0, "auto_b");
    end
    for (int j = 0; j < 4097; j++) begin
      exp_q.push_back(32'd0);
      issue(mk_fid(7'h10, 3'd1), 32'h0000_0999, 32'(j));
      if (j >= 4095) check("auto_a_wrap", 32'(a_index), 32'(j % 4096));
      wait_rsp(1, 2, 0, "auto_a");
    end
`endif

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
